// File: rtl/instruction_fetch_unit.sv
// Fetch stage: latches the PC, runs a request/acknowledge read and holds the word until the core accepts it.
// Optional request timeout is enabled by defining FETCH_TIMEOUT_EN.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_INSTRUCTION = 32'h00000013,
    parameter int unsigned TIMEOUT_CYCLES    = 256
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] pcOfInstruction,
    input  logic        programCounterMisaligned,
    output logic [31:0] memAddress,
    output logic        memRequest,
    input  logic        memAcknowledge,
    input  logic [31:0] memReadData,
    output logic [31:0] instruction,
    output logic        instructionValid,
    input  logic        instructionAccept,
    output logic        fetchFault,
    output logic        fetchTimeout
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQUEST = 2'd1,
        ST_HOLD    = 2'd2,
        ST_FAULT   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] mem_address_q, mem_address_d;
    logic [31:0] instruction_q, instruction_d;
    logic        mem_request_q, mem_request_d;
    logic        instruction_valid_q, instruction_valid_d;
    logic        fetch_fault_q, fetch_fault_d;

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned CW = (TIMEOUT_CYCLES > 32'd1) ? $clog2(TIMEOUT_CYCLES) : 1;
    // Counter holds the number of unacknowledged request cycles already spent.
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 32'd1);

    logic [CW-1:0] timeout_count_q, timeout_count_d;
    logic          fetch_timeout_q, fetch_timeout_d;
`endif

    // Next-state and next-output computation for the fetch FSM.
    always_comb begin
        state_d             = state_q;
        mem_address_d       = mem_address_q;
        instruction_d       = instruction_q;
        mem_request_d       = mem_request_q;
        instruction_valid_d = instruction_valid_q;
        fetch_fault_d       = fetch_fault_q;
`ifdef FETCH_TIMEOUT_EN
        timeout_count_d     = timeout_count_q;
        fetch_timeout_d     = fetch_timeout_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (programCounterMisaligned) begin
                    fetch_fault_d = 1'b1;
                    mem_request_d = 1'b0;
                    state_d       = ST_FAULT;
                end else begin
                    mem_address_d = pcOfInstruction;
                    mem_request_d = 1'b1;
                    state_d       = ST_REQUEST;
`ifdef FETCH_TIMEOUT_EN
                    timeout_count_d = '0;
`endif
                end
            end
            ST_REQUEST: begin
                // An ack in the last allowed cycle takes priority over the timeout.
                if (memAcknowledge) begin
                    instruction_d       = memReadData;
                    instruction_valid_d = 1'b1;
                    mem_request_d       = 1'b0;
                    state_d             = ST_HOLD;
                end else begin
`ifdef FETCH_TIMEOUT_EN
                    if (timeout_count_q == TIMEOUT_LAST) begin
                        mem_request_d   = 1'b0;
                        fetch_fault_d   = 1'b1;
                        fetch_timeout_d = 1'b1;
                        state_d         = ST_FAULT;
                    end else begin
                        timeout_count_d = timeout_count_q + {{(CW-1){1'b0}}, 1'b1};
                        state_d         = ST_REQUEST;
                    end
`else
                    state_d = ST_REQUEST;
`endif
                end
            end
            ST_HOLD: begin
                if (instructionAccept) begin
                    instruction_valid_d = 1'b0;
                    state_d             = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_FAULT: begin
                mem_request_d       = 1'b0;
                instruction_valid_d = 1'b0;
                fetch_fault_d       = 1'b1;
                state_d             = ST_FAULT;
            end
            default: begin
                mem_request_d       = 1'b0;
                instruction_valid_d = 1'b0;
                state_d             = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight request.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q             <= ST_IDLE;
            mem_address_q       <= 32'h0000_0000;
            instruction_q       <= RESET_INSTRUCTION;
            mem_request_q       <= 1'b0;
            instruction_valid_q <= 1'b0;
            fetch_fault_q       <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            timeout_count_q     <= '0;
            fetch_timeout_q     <= 1'b0;
`endif
        end else begin
            state_q             <= state_d;
            mem_address_q       <= mem_address_d;
            instruction_q       <= instruction_d;
            mem_request_q       <= mem_request_d;
            instruction_valid_q <= instruction_valid_d;
            fetch_fault_q       <= fetch_fault_d;
`ifdef FETCH_TIMEOUT_EN
            timeout_count_q     <= timeout_count_d;
            fetch_timeout_q     <= fetch_timeout_d;
`endif
        end
    end

    assign memAddress       = mem_address_q;
    assign memRequest       = mem_request_q;
    assign instruction      = instruction_q;
    assign instructionValid = instruction_valid_q;
    assign fetchFault       = fetch_fault_q;
`ifdef FETCH_TIMEOUT_EN
    assign fetchTimeout     = fetch_timeout_q;
`else
    assign fetchTimeout     = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed self-checking bench for instruction_fetch_unit (timeout cases only when FETCH_TIMEOUT_EN is defined).
module tb_instruction_fetch_unit;

    logic        clock;
    logic        reset;
    logic [31:0] pcOfInstruction;
    logic        programCounterMisaligned;
    logic [31:0] memAddress;
    logic        memRequest;
    logic        memAcknowledge;
    logic [31:0] memReadData;
    logic [31:0] instruction;
    logic        instructionValid;
    logic        instructionAccept;
    logic        fetchFault;
    logic        fetchTimeout;

    int tests_run    = 0;
    int tests_failed = 0;

    instruction_fetch_unit #(
        .RESET_INSTRUCTION (32'h00000013),
        .TIMEOUT_CYCLES    (4)
    ) dut (
        .clock                    (clock),
        .reset                    (reset),
        .pcOfInstruction          (pcOfInstruction),
        .programCounterMisaligned (programCounterMisaligned),
        .memAddress               (memAddress),
        .memRequest               (memRequest),
        .memAcknowledge           (memAcknowledge),
        .memReadData              (memReadData),
        .instruction              (instruction),
        .instructionValid         (instructionValid),
        .instructionAccept        (instructionAccept),
        .fetchFault               (fetchFault),
        .fetchTimeout             (fetchTimeout)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check_eq(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Advance to the next cycle and settle just after the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_pc(input logic [31:0] pc);
        pcOfInstruction          = pc;
        programCounterMisaligned = (pc[1:0] != 2'b00);
    endtask

    initial begin
        reset             = 1'b1;
        memAcknowledge    = 1'b0;
        memReadData       = 32'h0;
        instructionAccept = 1'b0;
        set_pc(32'h0000_0000);

        #12;
        check_eq("rst_req",   {31'd0, memRequest},       32'd0);
        check_eq("rst_valid", {31'd0, instructionValid}, 32'd0);
        check_eq("rst_instr", instruction,               32'h00000013);
        check_eq("rst_addr",  memAddress,                32'h0);
        check_eq("rst_fault", {31'd0, fetchFault},       32'd0);
        check_eq("rst_tmo",   {31'd0, fetchTimeout},     32'd0);
        reset = 1'b0;

        // Cycle 0 IDLE, zero-wait fetch.
        check_eq("c0_req", {31'd0, memRequest}, 32'd0);
        step(); // cycle 1
        check_eq("c1_req",   {31'd0, memRequest}, 32'd1);
        check_eq("c1_addr",  memAddress,          32'h0);
        check_eq("c1_instr", instruction,         32'h00000013);
        memAcknowledge = 1'b1;
        memReadData    = 32'h00500093;
        step(); // cycle 2: HOLD
        memAcknowledge = 1'b0;
        check_eq("c2_valid", {31'd0, instructionValid}, 32'd1);
        check_eq("c2_instr", instruction,               32'h00500093);
        check_eq("c2_req",   {31'd0, memRequest},       32'd0);
        instructionAccept = 1'b1;
        step(); // cycle 3: IDLE, samples PC 0
        instructionAccept = 1'b0;
        check_eq("c3_valid", {31'd0, instructionValid}, 32'd0);

        // Three wait cycles; PC moves and a stray accept arrives mid-request.
        step(); // cycle 4: REQUEST wait 1
        check_eq("c4_req",  {31'd0, memRequest}, 32'd1);
        check_eq("c4_addr", memAddress,          32'h0);
        set_pc(32'h0000_0004);
        instructionAccept = 1'b1;
        step(); // cycle 5: wait 2
        instructionAccept = 1'b0;
        check_eq("c5_addr", memAddress,               32'h0);
        check_eq("c5_req",  {31'd0, memRequest},      32'd1);
        check_eq("c5_valid", {31'd0, instructionValid}, 32'd0);
        step(); // cycle 6: wait 3
        check_eq("c6_addr", memAddress, 32'h0);
        step(); // cycle 7: ack
        check_eq("c7_addr", memAddress,          32'h0);
        check_eq("c7_req",  {31'd0, memRequest}, 32'd1);
        memAcknowledge = 1'b1;
        memReadData    = 32'h00a00113;
        step(); // cycle 8: valid five cycles after IDLE at cycle 3
        memAcknowledge = 1'b0;
        check_eq("c8_valid", {31'd0, instructionValid}, 32'd1);
        check_eq("c8_instr", instruction,               32'h00a00113);
        set_pc(32'h0000_0008);
        instructionAccept = 1'b1;
        step(); // cycle 9: IDLE
        instructionAccept = 1'b0;
        check_eq("c9_valid", {31'd0, instructionValid}, 32'd0);
        check_eq("c9_req",   {31'd0, memRequest},       32'd0);
        step(); // cycle 10: request carries the PC written at accept
        check_eq("c10_req",  {31'd0, memRequest}, 32'd1);
        check_eq("c10_addr", memAddress,          32'h8);
        memAcknowledge = 1'b1;
        memReadData    = 32'h00c00193;
        step(); // cycle 11
        memAcknowledge = 1'b0;
        check_eq("c11_instr", instruction, 32'h00c00193);
        step(); // cycle 12: still holding
        check_eq("c12_valid", {31'd0, instructionValid}, 32'd1);
        check_eq("c12_instr", instruction,               32'h00c00193);
        set_pc(32'h0000_0006);
        instructionAccept = 1'b1;
        step(); // cycle 13: IDLE with misaligned PC
        instructionAccept = 1'b0;
        check_eq("c13_instr_kept", instruction, 32'h00c00193);
        check_eq("c13_fault", {31'd0, fetchFault}, 32'd0);
        step(); // cycle 14: FAULT
        check_eq("c14_fault", {31'd0, fetchFault}, 32'd1);
        check_eq("c14_req",   {31'd0, memRequest}, 32'd0);
        memAcknowledge = 1'b1;
        set_pc(32'h0000_000c);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("fault_sticky", {31'd0, fetchFault},       32'd1);
            check_eq("fault_noreq",  {31'd0, memRequest},       32'd0);
            check_eq("fault_novld",  {31'd0, instructionValid}, 32'd0);
        end
        check_eq("fault_tmo", {31'd0, fetchTimeout}, 32'd0);
        memAcknowledge = 1'b0;

        // Reset in the middle of a request.
        reset = 1'b1;
        set_pc(32'h0000_0010);
        #1;
        check_eq("rst2_fault", {31'd0, fetchFault}, 32'd0);
        step();
        reset = 1'b0; // cycle 0 IDLE
        step(); // cycle 1 REQUEST
        check_eq("r1_req",  {31'd0, memRequest}, 32'd1);
        check_eq("r1_addr", memAddress,          32'h10);
        #2;
        reset = 1'b1;
        #1;
        check_eq("r_async_req",  {31'd0, memRequest}, 32'd0);
        check_eq("r_async_addr", memAddress,          32'h0);
        memAcknowledge = 1'b1;
        memReadData    = 32'hdeadbeef;
        #2;
        reset = 1'b0; // stray ack during IDLE
        step(); // REQUEST
        memAcknowledge = 1'b0;
        check_eq("r2_req",   {31'd0, memRequest},       32'd1);
        check_eq("r2_valid", {31'd0, instructionValid}, 32'd0);
        check_eq("r2_instr", instruction,               32'h00000013);
        check_eq("r2_addr",  memAddress,                32'h10);
        memAcknowledge = 1'b1;
        memReadData    = 32'h00208233;
        step();
        memAcknowledge = 1'b0;
        check_eq("r3_valid", {31'd0, instructionValid}, 32'd1);
        check_eq("r3_instr", instruction,               32'h00208233);

`ifdef FETCH_TIMEOUT_EN
        // No ack for four request cycles.
        reset = 1'b1;
        set_pc(32'h0000_0020);
        step();
        reset = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step();
            check_eq("tmo_req", {31'd0, memRequest}, 32'd1);
            check_eq("tmo_nof", {31'd0, fetchFault}, 32'd0);
        end
        step();
        check_eq("tmo_fault", {31'd0, fetchFault},   32'd1);
        check_eq("tmo_flag",  {31'd0, fetchTimeout}, 32'd1);
        check_eq("tmo_drop",  {31'd0, memRequest},   32'd0);

        // Ack in the fourth request cycle wins.
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            step();
        end
        step(); // fourth request cycle
        check_eq("ack4_req", {31'd0, memRequest}, 32'd1);
        memAcknowledge = 1'b1;
        memReadData    = 32'h00310313;
        step();
        memAcknowledge = 1'b0;
        check_eq("ack4_valid", {31'd0, instructionValid}, 32'd1);
        check_eq("ack4_instr", instruction,               32'h00310313);
        check_eq("ack4_fault", {31'd0, fetchFault},       32'd0);
        check_eq("ack4_tmo",   {31'd0, fetchTimeout},     32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Fetch stage that consumes the program counter's current value and misalignment flag, runs a request/acknowledge read against instruction memory, and holds the fetched word for the decode/execute stage. It sits directly downstream of the program counter. It presents one instruction at a time and starts the next fetch only after the core accepts the current one, so the PC is rewritten exactly once per instruction.

## Interface
- RESET_INSTRUCTION, 32'h00000013, value of `instruction` while no fetch has completed (NOP).
- TIMEOUT_CYCLES, 256, maximum `memRequest` cycles before a timeout fault; range 1..65535; used only with `FETCH_TIMEOUT_EN`.
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high.
- pcOfInstruction  in  32  current PC from the program counter.
- programCounterMisaligned  in  1  high when `pcOfInstruction[1:0] != 0`.
- memAddress  out  32  fetch address; value latched from PC, stable while `memRequest` is high.
- memRequest  out  1  read request; held high until acknowledged.
- memAcknowledge  in  1  memory returns `memReadData` this cycle; ignored when `memRequest` is low.
- memReadData  in  32  instruction word, valid with `memAcknowledge`.
- instruction  out  32  fetched instruction register.
- instructionValid  out  1  `instruction` holds an unconsumed fetched word.
- instructionAccept  in  1  core consumes the instruction this cycle; the PC is written in the same cycle.
- fetchFault  out  1  sticky fault; set by misalignment or timeout, cleared only by reset.
- fetchTimeout  out  1  sticky; high when the fault cause was a timeout.

## Operation
- FSM states:
  - IDLE: if `programCounterMisaligned`, go to FAULT. Otherwise latch `pcOfInstruction` into `memAddress` and go to REQUEST.
  - REQUEST: `memRequest` = 1. On `memAcknowledge`, load `memReadData` into `instruction`, set `instructionValid`, go to HOLD.
  - HOLD: `instructionValid` = 1. On `instructionAccept`, clear `instructionValid` and go to IDLE.
  - FAULT: terminal until reset. `memRequest` = 0, `instructionValid` = 0, `fetchFault` = 1.
- `instructionAccept` outside HOLD is ignored; it must not corrupt state.
- The PC is sampled only in IDLE. PC changes in REQUEST or HOLD do not affect `memAddress`.
- `instruction` keeps its last value after accept and changes only on the next acknowledge.
- Reset (asynchronous, any state):
  - FSM goes to IDLE.
  - `memRequest`, `instructionValid`, `fetchFault`, `fetchTimeout` = 0.
  - `memAddress` = 0; `instruction` = RESET_INSTRUCTION; timeout counter = 0.
  - A request in flight is abandoned. An acknowledge arriving after reset deasserts is ignored unless a new request is active.

## Timing
- Zero-wait memory (ack in the first REQUEST cycle):
  - cycle 0 IDLE, cycle 1 REQUEST, cycle 2 `instructionValid` = 1.
  - Minimum 2-cycle fetch latency.
  - Back-to-back throughput is one instruction per 3 cycles when accept comes in the first HOLD cycle.
- N wait cycles add N cycles of REQUEST.
- Accept in cycle t: `instructionValid` low at t+1 (IDLE), new request at t+2. The PC written at edge t is the value sampled in IDLE.
- Misaligned PC in IDLE: `fetchFault` high the next cycle; no request is issued.
- `memAddress` never changes while `memRequest` is high.

## Configuration
- `FETCH_TIMEOUT_EN` defined:
  - A counter with width sufficient for TIMEOUT_CYCLES clears on entry to REQUEST and increments each REQUEST cycle without acknowledge.
  - After TIMEOUT_CYCLES request cycles with no ack: drop `memRequest`, set `fetchFault` and `fetchTimeout`, go to FAULT.
  - An ack in the final allowed cycle wins over the timeout.
- `FETCH_TIMEOUT_EN` undefined: no counter; REQUEST waits indefinitely; `fetchTimeout` is tied to 0.

## Test plan
- Reset release, PC = 0x00000000, ack in first request cycle with data 0x00500093 -> `memAddress` = 0 with `memRequest` in cycle 1; `instruction` = 0x00500093 and `instructionValid` = 1 in cycle 2; before that, `instruction` = 0x00000013.
- Ack after 3 wait cycles; PC driven to 0x00000004 mid-request -> `memAddress` stays 0 throughout; valid 5 cycles after IDLE.
- Accept in the first HOLD cycle, PC then = 0x00000008 -> valid drops the next cycle; the next request carries 0x00000008 two cycles after accept. `instructionAccept` pulsed in IDLE/REQUEST -> no effect.
- PC = 0x00000006 in IDLE -> `fetchFault` = 1 the next cycle, `memRequest` never asserted, state persists until reset.
- Reset asserted mid-REQUEST -> `memRequest` drops immediately (before the next edge); a later stray ack is ignored; the fetch restarts cleanly.
- With `FETCH_TIMEOUT_EN` and TIMEOUT_CYCLES = 4:
  - no ack -> `fetchFault` = `fetchTimeout` = 1 after 4 request cycles;
  - ack in the 4th cycle -> normal fetch, no fault.
